// File: rtl/cpu_lcd_pkg.sv
// Shared types, LCD command constants and helpers for the LCD result writer.
package cpu_lcd_pkg;

    typedef enum logic [1:0] {
        ST_PWR_WAIT = 2'd0,
        ST_INIT     = 2'd1,
        ST_IDLE     = 2'd2,
        ST_SEND     = 2'd3
    } lcd_state_e;

    typedef enum logic {
        PH_EN_HI = 1'b0,
        PH_EN_LO = 1'b1
    } lcd_phase_e;

    typedef struct packed {
        logic [3:0]  reg_idx;
        logic [15:0] value;
    } lcd_result_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;

    // Uppercase ASCII for one hex nibble ('A' - 10 == 8'h37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_result_writer_if.sv
// Result handshake between the operation stage (master) and the LCD writer (slave).
interface lcd_result_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_value;

    modport master (output in_valid, output in_reg, output in_value, input in_ready);
    modport slave  (input in_valid, input in_reg, input in_value, output in_ready);
endinterface

// File: rtl/lcd_delay.sv
// Loadable down-counter: load N-1, done is high once the count has reached zero.
module lcd_delay #(
    parameter int unsigned         W       = 8,
    parameter logic [W-1:0]        RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
            done  <= (RST_VAL == '0);
        end else begin
            cnt_q <= cnt_d;
            done  <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/lcd_result_writer.sv
// Writes "R<d>=<hhhh>" to line 1 of an HD44780 LCD for each accepted result.
// Define LCD_INIT_EN to run the power-on wait and panel init after every reset.
module lcd_result_writer
    import cpu_lcd_pkg::*;
#(
    parameter int unsigned T_EN  = 25,
    parameter int unsigned T_CMD = 2000,
    parameter int unsigned T_CLR = 100000,
    parameter int unsigned T_PWR = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    lcd_result_writer_if.slave        res,
    output logic                      lcd_en,
    output logic                      lcd_rs,
    output logic                      lcd_rw,
    output logic [7:0]                lcd_data
);

    localparam int unsigned DLY_MAX = max_u(max_u(T_PWR, T_CLR), max_u(T_EN, T_CMD));
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0] EN_LD  = DLY_W'(T_EN - 1);
    localparam logic [DLY_W-1:0] CMD_LD = DLY_W'(T_CMD - 1);
    localparam logic [DLY_W-1:0] CLR_LD = DLY_W'(T_CLR - 1);
`ifdef LCD_INIT_EN
    localparam lcd_state_e       RST_STATE = ST_PWR_WAIT;
    localparam logic [DLY_W-1:0] RST_DLY   = DLY_W'(T_PWR - 1);
`else
    localparam lcd_state_e       RST_STATE = ST_IDLE;
    localparam logic [DLY_W-1:0] RST_DLY   = '0;
`endif

    lcd_state_e       state;
    lcd_phase_e       phase;
    logic [2:0]       idx;
    lcd_result_t      res_q;
    logic             ready_q;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;

    logic             dly_done;
    logic             dly_load_c;
    logic [DLY_W-1:0] dly_val_c;
    logic             accept_c;
    logic             last_c;
    logic [8:0]       nxt_c;

    // {rs, data} of byte i in the init or send sequence.
    function automatic logic [8:0] byte_at(input lcd_state_e st, input logic [2:0] i,
                                           input lcd_result_t r);
        logic [8:0] b;
        b = {1'b0, LCD_LINE1};
        if (st == ST_INIT) begin
            case (i)
                3'd0, 3'd1, 3'd2, 3'd3: b = {1'b0, LCD_FUNC_SET};
                3'd4:                   b = {1'b0, LCD_DISP_ON};
                3'd5:                   b = {1'b0, LCD_CLEAR};
                default:                b = {1'b0, LCD_ENTRY};
            endcase
        end else begin
            case (i)
                3'd0:    b = {1'b0, LCD_LINE1};
                3'd1:    b = {1'b1, 8'h52};
                3'd2:    b = {1'b1, hex_ascii(r.reg_idx)};
                3'd3:    b = {1'b1, 8'h3D};
                3'd4:    b = {1'b1, hex_ascii(r.value[15:12])};
                3'd5:    b = {1'b1, hex_ascii(r.value[11:8])};
                3'd6:    b = {1'b1, hex_ascii(r.value[7:4])};
                default: b = {1'b1, hex_ascii(r.value[3:0])};
            endcase
        end
        return b;
    endfunction

    assign accept_c = (state == ST_IDLE) && ready_q && res.in_valid;
    assign last_c   = ((state == ST_SEND) && (idx == 3'd7)) || ((state == ST_INIT) && (idx == 3'd6));
    assign nxt_c    = byte_at(state, idx + 3'd1, res_q);

    // Delay reload follows the FSM edge that starts each phase.
    always_comb begin
        dly_load_c = 1'b0;
        dly_val_c  = EN_LD;
        case (state)
            ST_IDLE:     dly_load_c = accept_c;
            ST_PWR_WAIT: dly_load_c = dly_done;
            default: begin
                if (phase == PH_EN_HI) begin
                    dly_load_c = dly_done;
                    dly_val_c  = (!rs_q && (data_q == LCD_CLEAR)) ? CLR_LD : CMD_LD;
                end else begin
                    dly_load_c = dly_done && !last_c;
                end
            end
        endcase
    end

    lcd_delay #(.W(DLY_W), .RST_VAL(RST_DLY)) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dly_load_c),
        .value (dly_val_c),
        .done  (dly_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            phase   <= PH_EN_HI;
            idx     <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state)
`ifdef LCD_INIT_EN
                ST_PWR_WAIT: begin
                    if (dly_done) begin
                        state  <= ST_INIT;
                        phase  <= PH_EN_HI;
                        idx    <= '0;
                        en_q   <= 1'b1;
                        rs_q   <= 1'b0;
                        data_q <= LCD_FUNC_SET;
                    end
                end
`endif
                ST_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (res.in_valid) begin
                        ready_q <= 1'b0;
                        state   <= ST_SEND;
                        res_q   <= '{reg_idx: res.in_reg, value: res.in_value};
                        phase   <= PH_EN_HI;
                        idx     <= '0;
                        en_q    <= 1'b1;
                        rs_q    <= 1'b0;
                        data_q  <= LCD_LINE1;
                    end
                end
                default: begin
                    // rs/data only move on the edge that raises lcd_en.
                    if (dly_done) begin
                        if (phase == PH_EN_HI) begin
                            phase <= PH_EN_LO;
                            en_q  <= 1'b0;
                        end else if (last_c) begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            phase          <= PH_EN_HI;
                            idx            <= idx + 3'd1;
                            en_q           <= 1'b1;
                            {rs_q, data_q} <= nxt_c;
                        end
                    end
                end
            endcase
        end
    end

    assign res.in_ready = ready_q;
    assign lcd_en       = en_q;
    assign lcd_rs       = rs_q;
    assign lcd_rw       = 1'b0;
    assign lcd_data     = data_q;

endmodule

// File: tb/tb_lcd_result_writer.sv
// Scoreboard bench for lcd_result_writer; expected LCD bytes are queued at accept
// and popped by a monitor on every rising lcd_en.
module tb_lcd_result_writer;

    localparam int unsigned T_EN  = 2;
    localparam int unsigned T_CMD = 5;
    localparam int unsigned T_CLR = 10;
    localparam int unsigned T_PWR = 20;
    localparam int SEND_LEN = 56;
`ifdef LCD_INIT_EN
    localparam int EXP_RDY  = 74;
`else
    localparam int EXP_RDY  = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    lcd_result_writer_if rif ();

    lcd_result_writer #(
        .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .res      (rif),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop on each lcd_en rise, then require rs/data held until the next rise.
    logic       prev_en = 1'b0;
    logic       holding = 1'b0;
    logic [8:0] held_byte = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            holding = 1'b0;
        end else begin
            if (lcd_en && !prev_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got rs=%0d data=0x%02h expected none", lcd_rs, lcd_data);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({lcd_rs, lcd_data} !== e) begin
                        n_fail++;
                        $display("FAIL lcd_byte: got rs=%0d data=0x%02h expected rs=%0d data=0x%02h",
                                 lcd_rs, lcd_data, e[8], e[7:0]);
                    end
                end
                held_byte = {lcd_rs, lcd_data};
                holding = 1'b1;
            end else if (holding) begin
                n_checks++;
                if ({lcd_rs, lcd_data} !== held_byte || lcd_rw !== 1'b0) begin
                    n_fail++;
                    $display("FAIL byte_hold: got rs=%0d data=0x%02h rw=%0d expected rs=%0d data=0x%02h rw=0",
                             lcd_rs, lcd_data, lcd_rw, held_byte[8], held_byte[7:0]);
                end
            end
            prev_en = lcd_en;
        end
    end

    // First byte is the rs=0 line-1 command, the other seven are rs=1 characters.
    task automatic push_txn(input logic [63:0] b);
        exp_q.push_back({1'b0, b[63:56]});
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] d;
            d = b[i*8 +: 8];
            exp_q.push_back({1'b1, d});
        end
    endtask

    task automatic reset_release();
        int base;
        int en_edge;
        int rdy_edge;
        en_edge = 0;
        rdy_edge = 0;
`ifdef LCD_INIT_EN
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
`endif
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        for (int i = 0; i < 2000 && rdy_edge == 0; i++) begin
            @(negedge clk);
            if (lcd_en && en_edge == 0) en_edge = cyc - base;
            if (rif.in_ready) rdy_edge = cyc - base;
        end
        check("ready_after_reset", rdy_edge, EXP_RDY);
`ifdef LCD_INIT_EN
        check("pwr_wait_len", en_edge, int'(T_PWR));
        check("init_bytes_done", exp_q.size(), 0);
`else
        check("no_init_bytes", en_edge, 0);
`endif
    endtask

    // Present a result (called at a negedge) and wait for the accepting edge k.
    task automatic do_txn(input logic [3:0] r, input logic [15:0] v,
                          input logic [63:0] exp_bytes, output int k);
        rif.in_valid = 1'b1;
        rif.in_reg   = r;
        rif.in_value = v;
        k = -1;
        for (int i = 0; i < 500; i++) begin
            if (rif.in_ready) begin
                k = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (k < 0) begin
            check("accept_timeout", 0, 1);
        end else begin
            push_txn(exp_bytes);
            @(negedge clk);
            check("accept_en", int'(lcd_en), 1);
            check("accept_busy", int'(rif.in_ready), 0);
            rif.in_valid = 1'b0;
            rif.in_reg   = ~r;
            rif.in_value = ~v;
        end
    endtask

    task automatic wait_ready(input int k, output int e);
        e = -1;
        for (int i = 0; i < 500; i++) begin
            if (rif.in_ready) begin
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        check("send_len", e - k, SEND_LEN);
    endtask

    initial begin
        int k;
        int e;
        rif.in_valid = 1'b0;
        rif.in_reg   = 4'h0;
        rif.in_value = 16'h0000;

        #12;
        check("rst_en", int'(lcd_en), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_rw", int'(lcd_rw), 0);
        check("rst_data", int'(lcd_data), 0);
        check("rst_ready", int'(rif.in_ready), 0);

        reset_release();

        do_txn(4'h3, 16'hBEEF, 64'h80_52_33_3D_42_45_45_46, k);
        wait_ready(k, e);

        do_txn(4'hF, 16'h09A0, 64'h80_52_46_3D_30_39_41_30, k);
        wait_ready(k, e);

        // Busy-time valid pulse must be ignored; a held valid is taken at once.
        do_txn(4'hA, 16'h0000, 64'h80_52_41_3D_30_30_30_30, k);
        repeat (10) @(negedge clk);
        rif.in_valid = 1'b1;
        rif.in_reg   = 4'h1;
        rif.in_value = 16'h1234;
        repeat (3) @(negedge clk);
        rif.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rif.in_valid = 1'b1;
        rif.in_reg   = 4'h5;
        rif.in_value = 16'h5A5A;
        wait_ready(k, e);
        do_txn(4'h5, 16'h5A5A, 64'h80_52_35_3D_35_41_35_41, k);
        check("back_to_back", k, e + 1);
        wait_ready(k, e);

        // Reset while the 'R' data byte has lcd_en high.
        do_txn(4'h6, 16'h7777, 64'h80_52_36_3D_37_37_37_37, k);
        repeat (7) @(negedge clk);
        check("pre_rst_en", int'(lcd_en), 1);
        check("pre_rst_rs", int'(lcd_rs), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_en", int'(lcd_en), 0);
        check("async_rst_rs", int'(lcd_rs), 0);
        check("async_rst_data", int'(lcd_data), 0);
        check("async_rst_ready", int'(rif.in_ready), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_release();

        do_txn(4'h7, 16'h1C4D, 64'h80_52_37_3D_31_43_34_44, k);
        wait_ready(k, e);
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
